// File: rtl/priority_irq_ctrl.sv
// Registered N-line priority encoder: captures requests into a pending vector and
// presents one granted index at a time over a valid/ready handshake.
module priority_irq_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter bit RR    = 1'b0,
    parameter bit EDGE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N-1:0]     pend,
    output logic             any_pend
);

    typedef enum logic [0:0] {IDLE, PRESENT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     req_q, pend_q, pend_d;
    logic [N-1:0]     set_vec, clr_vec, cand;
    logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d;
    logic [IDX_W-1:0] base, sel, pos;
    logic             any_pend_q, any_pend_d, xfer, found;

    assign xfer = (state_q == PRESENT) && out_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_clr
        assign clr_vec[gi] = xfer && (idx_q == IDX_W'(gi));
    end

    // Set is OR-ed after the clear so an event coinciding with its own ack survives.
    always_comb begin
        set_vec    = EDGE ? (req & ~req_q) : req;
        pend_d     = (pend_q & ~clr_vec) | set_vec;
        any_pend_d = |pend_d;
        cand       = pend_d & mask;
        ptr_d      = (RR && xfer) ? idx_q : ptr_q;
    end

    // Search descends from base-1 with wrap; fixed priority is the same walk from base 0.
    // The walk runs lowest-priority first so the last hit is the winner.
    always_comb begin
        base  = RR ? ptr_d : '0;
        sel   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IDX_W'((int'(base) + N - k) % N);
            if (cand[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = PRESENT;
                    idx_d   = sel;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (found) begin
                        idx_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            pend_q     <= '0;
            any_pend_q <= 1'b0;
            req_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            pend_q     <= pend_d;
            any_pend_q <= any_pend_d;
            req_q      <= req;
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_idx   = idx_q;
    assign pend      = pend_q;
    assign any_pend  = any_pend_q;

endmodule
